// File: rtl/bloom_pkg.sv
// bloom_pkg: op codes, sequencer states and multiplicative hash seeds shared by the
// Bloom-filter instruction unit.
package bloom_pkg;

  typedef enum logic [4:0] {
    OP_INSERT = 5'b00001,
    OP_RESET  = 5'b00011,
    OP_CHECK  = 5'b00100
  } bloom_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_UPD,
    ST_CMP,
    ST_CLR,
    ST_DONE
  } bloom_state_e;

  // Odd seeds so each multiply is a bijection on the 32-bit key; entry 0 feeds probe 0.
  localparam logic [3:0][31:0] HASH_SEED = {
    32'h27D4_EB2F,
    32'hC2B2_AE3D,
    32'h85EB_CA77,
    32'h9E37_79B1
  };

endpackage

// File: rtl/bloom_hash.sv
// bloom_hash: multiplicative hash of a key with one seed; the top IW bits of the
// 32-bit product split into a filter word address and a bit select.
module bloom_hash #(
  parameter int IW = 10,
  parameter int BW = 5
) (
  input  logic [31:0]      key,
  input  logic [31:0]      seed,
  output logic [IW-BW-1:0] word_addr,
  output logic [BW-1:0]    bit_sel
);

  logic [31:0]   product;
  logic [IW-1:0] idx;

  assign product   = key * seed;
  assign idx       = IW'(product >> (32 - IW));
  assign word_addr = idx[IW-1:BW];
  assign bit_sel   = idx[BW-1:0];

endmodule

// File: rtl/bloom_op_ctrl.sv
// bloom_op_ctrl: sequencer for Bloom-filter insert/check/clear custom ops on a word-wide RAM.
// Define BLOOM_CTRL_STATS_EN to build the saturating insert counter on insert_cnt_o.
module bloom_op_ctrl
  import bloom_pkg::*;
#(
  parameter int FILTER_BITS = 1024,
  parameter int WORD_W      = 32,
  parameter int NUM_HASH    = 3,
  parameter int KEY_W       = 8,
  parameter int AW          = $clog2(FILTER_BITS / WORD_W)
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_op_i,
  input  logic [31:0]       req_key_i,
  output logic              resp_valid_o,
  output logic              resp_match_o,
  output logic              resp_err_o,
  output logic              busy_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic [15:0]       insert_cnt_o
);

  localparam int          IW       = $clog2(FILTER_BITS);
  localparam int          BW       = $clog2(WORD_W);
  localparam int          DEPTH    = FILTER_BITS / WORD_W;
  localparam logic [31:0] KEY_MASK = (KEY_W >= 32) ? 32'hFFFF_FFFF : ((32'h1 << KEY_W) - 32'h1);
  localparam logic [1:0]  LAST_H   = 2'(NUM_HASH - 1);
  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

  bloom_state_e  state;
  logic [4:0]    op_q;
  logic [31:0]   key_q;
  logic [1:0]    h_q;
  logic [AW-1:0] a_q;
  logic          match_q;
  logic          err_q;
  logic [AW-1:0] word_addr;
  logic [BW-1:0] bit_sel;

  bloom_hash #(.IW(IW), .BW(BW)) u_hash (
    .key       (key_q),
    .seed      (HASH_SEED[h_q]),
    .word_addr (word_addr),
    .bit_sel   (bit_sel)
  );

  // Check exits on the first clear probe; insert walks every probe with a read-modify-write.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      key_q   <= '0;
      h_q     <= '0;
      a_q     <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_q    <= req_op_i;
            key_q   <= req_key_i & KEY_MASK;
            h_q     <= '0;
            a_q     <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
            case (req_op_i)
              OP_INSERT, OP_CHECK: state <= ST_RD;
              OP_RESET:            state <= ST_CLR;
              default: begin
                err_q <= 1'b1;
                state <= ST_DONE;
              end
            endcase
          end
        end
        ST_RD: state <= (op_q == OP_INSERT) ? ST_UPD : ST_CMP;
        ST_UPD: begin
          if (h_q == LAST_H) begin
            state <= ST_DONE;
          end else begin
            h_q   <= h_q + 2'd1;
            state <= ST_RD;
          end
        end
        ST_CMP: begin
          if (!mem_rdata_i[bit_sel]) begin
            state <= ST_DONE;
          end else if (h_q == LAST_H) begin
            match_q <= 1'b1;
            state   <= ST_DONE;
          end else begin
            h_q   <= h_q + 2'd1;
            state <= ST_RD;
          end
        end
        ST_CLR: begin
          if (a_q == LAST_A) begin
            state <= ST_DONE;
          end else begin
            a_q <= a_q + AW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      ST_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = word_addr;
      end
      ST_UPD: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = word_addr;
        mem_wdata_o = mem_rdata_i | (WORD_W'(1) << bit_sel);
      end
      ST_CLR: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = a_q;
      end
      default: ;
    endcase
  end

  assign req_ready_o  = (state == ST_IDLE);
  assign busy_o       = (state != ST_IDLE);
  assign resp_valid_o = (state == ST_DONE);
  assign resp_match_o = resp_valid_o & match_q;
  assign resp_err_o   = resp_valid_o & err_q;

`ifdef BLOOM_CTRL_STATS_EN
  logic [15:0] insert_cnt_q;

  // Counts completed inserts; a clear op zeroes it when it completes.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      insert_cnt_q <= '0;
    end else if (state == ST_DONE) begin
      if (op_q == OP_RESET) begin
        insert_cnt_q <= '0;
      end else if (op_q == OP_INSERT && insert_cnt_q != 16'hFFFF) begin
        insert_cnt_q <= insert_cnt_q + 16'd1;
      end
    end
  end

  assign insert_cnt_o = insert_cnt_q;
`else
  assign insert_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_bloom_op_ctrl.sv
// tb_bloom_op_ctrl: scoreboard bench for bloom_op_ctrl with a behavioural filter RAM
// and an independent bit-level model of the filter contents.
module tb_bloom_op_ctrl;

`ifdef BLOOM_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic [4:0]  req_op = '0;
  logic [31:0] req_key = '0;
  logic        resp_valid_o, resp_match_o, resp_err_o, busy_o;
  logic        mem_req_o, mem_we_o;
  logic [4:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] ram_rdata = '0;
  logic [15:0] insert_cnt_o;

  logic [31:0] ram [32];

  typedef struct {
    logic match;
    logic err;
    int   lat;
  } exp_t;

  exp_t        sb[$];
  logic [36:0] wr_q[$];
  logic [36:0] rd_q[$];
  bit [1023:0] ref_bits;
  int          exp_ins = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  bloom_op_ctrl dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op),
    .req_key_i    (req_key),
    .resp_valid_o (resp_valid_o),
    .resp_match_o (resp_match_o),
    .resp_err_o   (resp_err_o),
    .busy_o       (busy_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (ram_rdata),
    .insert_cnt_o (insert_cnt_o)
  );

  always #5 clk = ~clk;

  // Filter RAM: read data appears the cycle after the read request.
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      else          ram_rdata <= ram[mem_addr_o];
    end
  end

  function automatic logic [9:0] b_idx(input logic [31:0] key, input int h);
    logic [31:0] s, p;
    case (h)
      0:       s = 32'h9E37_79B1;
      1:       s = 32'h85EB_CA77;
      2:       s = 32'hC2B2_AE3D;
      default: s = 32'h27D4_EB2F;
    endcase
    p = (key & 32'h0000_00FF) * s;
    return p[31:22];
  endfunction

  function automatic exp_t predict_check(input logic [31:0] key);
    exp_t e;
    e.err = 1'b0; e.match = 1'b1; e.lat = 7;
    for (int h = 2; h >= 0; h--) begin
      if (!ref_bits[b_idx(key, h)]) begin
        e.match = 1'b0;
        e.lat   = 2 * h + 3;
      end
    end
    return e;
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [31:0] key,
                        output int lat, output logic m, output logic er, output bit to);
    int w;
    wr_q.delete(); rd_q.delete();
    lat = 0; m = 1'b0; er = 1'b0; to = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_key = key;
    w = 0;
    while (!req_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = '0; req_key = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (mem_req_o) begin
        if (mem_we_o) wr_q.push_back({mem_addr_o, mem_wdata_o});
        else          rd_q.push_back({mem_addr_o, mem_wdata_o});
      end
      if (resp_valid_o) begin
        lat = i; m = resp_match_o; er = resp_err_o; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready_o); end
    n_cmp++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_cmp++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin n_err++; $display("FAIL rst_mem: got req=%b we=%b addr=%0d wdata=%h want all 0", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
    n_cmp++; if (insert_cnt_o !== 16'h0) begin n_err++; $display("FAIL rst_insert_cnt: got %0d want 0", insert_cnt_o); end
    rst_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: got ready=%b busy=%b want 1/0", req_ready_o, busy_o); end
  endtask

  task automatic test_clear();
    int lat; logic m, er; bit to; exp_t p, e; int bad;
    p.match = 1'b0; p.err = 1'b0; p.lat = 33; sb.push_back(p);
    run_op(5'b00011, 32'h0, lat, m, er, to);
    e = sb.pop_front();
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL clear_timeout: got no response want response"); end
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL clear_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if ({m, er} !== {e.match, e.err}) begin n_err++; $display("FAIL clear_resp: got match=%b err=%b want %b/%b", m, er, e.match, e.err); end
    n_cmp++; if (wr_q.size() !== 32 || rd_q.size() !== 0) begin n_err++; $display("FAIL clear_access_cnt: got wr=%0d rd=%0d want 32/0", wr_q.size(), rd_q.size()); end
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== {5'(i), 32'h0}) bad++;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL clear_write_seq: got %0d bad writes want 0", bad); end
    bad = 0;
    for (int i = 0; i < 32; i++) if (ram[i] !== 32'h0) bad++;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL clear_ram: got %0d nonzero words want 0", bad); end
    ref_bits = '0;
    exp_ins = 0;
    @(negedge clk);
    n_cmp++; if (insert_cnt_o !== 16'h0) begin n_err++; $display("FAIL clear_insert_cnt: got %0d want 0", insert_cnt_o); end
  endtask

  task automatic test_check(input logic [31:0] key, input string name);
    int lat; logic m, er; bit to; exp_t e; int nrd; int bad;
    sb.push_back(predict_check(key));
    run_op(5'b00100, key, lat, m, er, to);
    e = sb.pop_front();
    nrd = (e.lat - 1) / 2;
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL %s_timeout: got no response want response", name); end
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL %s_lat: got %0d want %0d", name, lat, e.lat); end
    n_cmp++; if ({m, er} !== {e.match, e.err}) begin n_err++; $display("FAIL %s_resp: got match=%b err=%b want %b/%b", name, m, er, e.match, e.err); end
    n_cmp++; if (rd_q.size() !== nrd || wr_q.size() !== 0) begin n_err++; $display("FAIL %s_access_cnt: got rd=%0d wr=%0d want %0d/0", name, rd_q.size(), wr_q.size(), nrd); end
    bad = 0;
    for (int h = 0; h < rd_q.size() && h < 3; h++) begin
      logic [9:0] idx;
      idx = b_idx(key, h);
      if (rd_q[h] !== {idx[9:5], 32'h0}) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL %s_read_addr: got %0d bad reads want 0", name, bad); end
  endtask

  task automatic test_insert(input logic [31:0] key, input string name);
    int lat; logic m, er; bit to; exp_t p, e; int bad;
    logic [9:0] idx; logic [4:0] wa;
    p.match = 1'b0; p.err = 1'b0; p.lat = 7; sb.push_back(p);
    run_op(5'b00001, key, lat, m, er, to);
    e = sb.pop_front();
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL %s_timeout: got no response want response", name); end
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL %s_lat: got %0d want %0d", name, lat, e.lat); end
    n_cmp++; if ({m, er} !== {e.match, e.err}) begin n_err++; $display("FAIL %s_resp: got match=%b err=%b want %b/%b", name, m, er, e.match, e.err); end
    n_cmp++; if (rd_q.size() !== 3 || wr_q.size() !== 3) begin n_err++; $display("FAIL %s_access_cnt: got rd=%0d wr=%0d want 3/3", name, rd_q.size(), wr_q.size()); end
    bad = 0;
    for (int h = 0; h < 3; h++) begin
      idx = b_idx(key, h);
      wa = idx[9:5];
      ref_bits[idx] = 1'b1;
      if (h < wr_q.size() && wr_q[h] !== {wa, ref_bits[int'(wa) * 32 +: 32]}) bad++;
      if (h < rd_q.size() && rd_q[h] !== {wa, 32'h0}) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL %s_rmw: got %0d bad accesses want 0", name, bad); end
    exp_ins++;
    @(negedge clk);
    n_cmp++; if (insert_cnt_o !== (STATS ? 16'(exp_ins) : 16'h0)) begin n_err++; $display("FAIL %s_insert_cnt: got %0d want %0d", name, insert_cnt_o, STATS ? exp_ins : 0); end
  endtask

  task automatic test_bad_op();
    logic [4:0] codes [3];
    int lat; logic m, er; bit to; exp_t p, e;
    codes[0] = 5'b00111; codes[1] = 5'b00000; codes[2] = 5'b11111;
    for (int k = 0; k < 3; k++) begin
      p.match = 1'b0; p.err = 1'b1; p.lat = 1; sb.push_back(p);
      run_op(codes[k], 32'h5A, lat, m, er, to);
      e = sb.pop_front();
      n_cmp++; if (to !== 1'b0 || lat !== e.lat) begin n_err++; $display("FAIL bad_op_lat: op=%b got %0d want %0d", codes[k], lat, e.lat); end
      n_cmp++; if ({m, er} !== {e.match, e.err}) begin n_err++; $display("FAIL bad_op_resp: op=%b got match=%b err=%b want %b/%b", codes[k], m, er, e.match, e.err); end
      n_cmp++; if (rd_q.size() !== 0 || wr_q.size() !== 0) begin n_err++; $display("FAIL bad_op_mem: op=%b got rd=%0d wr=%0d want 0/0", codes[k], rd_q.size(), wr_q.size()); end
    end
  endtask

  task automatic test_back_to_back();
    int acc_at[$]; int resp_at[$]; exp_t p, e;
    p.match = 1'b0; p.err = 1'b0; p.lat = 7;
    sb.push_back(p); sb.push_back(p);
    @(negedge clk);
    req_valid = 1'b1; req_op = 5'b00001; req_key = 32'h33;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) @(negedge clk);
      if (resp_valid_o) begin
        resp_at.push_back(i);
        e = sb.pop_front();
        n_cmp++; if ({resp_match_o, resp_err_o} !== {e.match, e.err}) begin n_err++; $display("FAIL b2b_resp: got match=%b err=%b want %b/%b", resp_match_o, resp_err_o, e.match, e.err); end
      end
      if (req_ready_o && req_valid) begin
        acc_at.push_back(i);
        if (acc_at.size() == 2) begin
          @(posedge clk);
          #1;
          req_valid = 1'b0; req_op = '0; req_key = '0;
        end
      end
    end
    req_valid = 1'b0;
    n_cmp++; if (acc_at.size() !== 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", acc_at.size()); end
    n_cmp++; if (acc_at.size() < 2 || acc_at[1] !== 8) begin n_err++; $display("FAIL b2b_second_accept: got cycle %0d want 8", acc_at.size() < 2 ? -1 : acc_at[1]); end
    n_cmp++; if (resp_at.size() !== 2 || resp_at[0] !== 7 || resp_at[1] !== 15) begin n_err++; $display("FAIL b2b_resp_timing: got %0d resps first %0d want 2 at 7/15", resp_at.size(), resp_at.size() > 0 ? resp_at[0] : -1); end
    for (int h = 0; h < 3; h++) ref_bits[b_idx(32'h33, h)] = 1'b1;
    exp_ins += 2;
    n_cmp++; if (insert_cnt_o !== (STATS ? 16'(exp_ins) : 16'h0)) begin n_err++; $display("FAIL b2b_insert_cnt: got %0d want %0d", insert_cnt_o, STATS ? exp_ins : 0); end
    sb.delete();
  endtask

  task automatic test_reset_mid_op();
    int resp_seen;
    @(negedge clk);
    n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL midrst_ready_before: got %b want 1", req_ready_o); end
    req_valid = 1'b1; req_op = 5'b00011; req_key = '0;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = '0;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    n_cmp++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b1, 5'd9}) begin n_err++; $display("FAIL midrst_t10_write: got req=%b we=%b addr=%0d want 1/1/9", mem_req_o, mem_we_o, mem_addr_o); end
    rst_i = 1'b1;
    #1;
    n_cmp++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_idle: got ready=%b busy=%b want 1/0", req_ready_o, busy_o); end
    n_cmp++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, resp_valid_o} !== '0) begin n_err++; $display("FAIL midrst_outputs: got req=%b we=%b addr=%0d resp=%b want 0", mem_req_o, mem_we_o, mem_addr_o, resp_valid_o); end
    n_cmp++; if (insert_cnt_o !== 16'h0) begin n_err++; $display("FAIL midrst_insert_cnt: got %0d want 0", insert_cnt_o); end
    @(negedge clk);
    rst_i = 1'b0;
    resp_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid_o || mem_req_o) resp_seen++;
    end
    n_cmp++; if (resp_seen !== 0) begin n_err++; $display("FAIL midrst_no_resp: got %0d active cycles want 0", resp_seen); end
    for (int a = 0; a < 9; a++) ref_bits[a * 32 +: 32] = '0;
    exp_ins = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = $urandom;
    #2 rst_i = 1'b1;
    test_reset();
    test_clear();
    test_check(32'h5A, "check_empty");
    test_insert(32'hABCD_125A, "insert_5a");
    test_check(32'h5A, "check_hit");
    test_check(32'h77, "check_other");
    test_insert(32'hC3, "insert_c3");
    test_check(32'hFFFF_FFC3, "check_c3_hi");
    test_bad_op();
    test_back_to_back();
    test_check(32'h33, "check_33");
    test_reset_mid_op();
    test_check(32'h5A, "check_after_rst");
    test_check(32'h33, "check33_after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
